// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the BCD display path: digit triple layout
// and seven-segment glyph patterns (bit 7 = dp, bits 6:0 = g..a).
package seg_scan_driver_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_E = 8'h79;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_triple_t;

endpackage

// File: rtl/seg_scan_driver_seg7_encode.sv
// Combinational BCD to seven-segment glyph; any non-BCD code shows 'E'.
module seg7_encode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit seven-segment driver with frame-synchronous
// shadow/active digit registers, leading-zero blanking and per-slot dead time.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    output logic [7:0] seg_out,
    output logic [2:0] digit_sel,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             first;
    bcd_triple_t      shadow;
    bcd_triple_t      active;

    logic             cnt_last;
    logic             boundary;
    logic             dead;
    logic             blank;
    logic [3:0]       cur_digit;
    logic [7:0]       cur_seg;
    logic [NUM_DIGITS-1:0] sel_onehot;

    assign cnt_last = (cnt == CNT_W'(SCAN_DIV - 1));
    // first marks the cycle right after reset release, which also reloads active
    assign boundary = first | (cnt_last & (idx == 2'd2));
    assign dead     = (32'(cnt) < DEAD_CYCLES);

    always_comb begin
        cur_digit = active.hundreds;
        blank     = 1'b0;
        case (idx)
            2'd0: cur_digit = active.ones;
            2'd1: begin
                cur_digit = active.tens;
                blank     = (active.hundreds == 4'd0) && (active.tens == 4'd0);
            end
            default: begin
                cur_digit = active.hundreds;
                blank     = (active.hundreds == 4'd0);
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign sel_onehot[gi] = (idx == 2'(gi));
    end

    seg7_encode u_encode (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            first      <= 1'b1;
            shadow     <= '0;
            active     <= '0;
            seg_out    <= 8'h00;
            digit_sel  <= 3'b000;
            frame_tick <= 1'b0;
        end else begin
            first <= 1'b0;
            if (cnt_last) begin
                cnt <= '0;
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (boundary)
                active <= shadow;
            if (update)
                shadow <= '{hundreds: hundreds, tens: tens, ones: ones};
            frame_tick <= boundary;
            if (dead || blank) begin
                seg_out   <= 8'h00;
                digit_sel <= 3'b000;
            end else begin
                seg_out   <= cur_seg;
                digit_sel <= sel_onehot;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level reference model predicts
// each cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam int DC = 1;
    localparam int FR = 3 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       update = 1'b0;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0;
    logic [7:0] seg_out;
    logic [2:0] digit_sel;
    logic       frame_tick;

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (rst),
        .update     (update),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .seg_out    (seg_out),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [2:0] sel;
        logic       tick;
        logic [15:0] k;
    } exp_t;

    logic [7:0]  enc_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h79, 8'h79, 8'h79, 8'h79, 8'h79, 8'h79};
    logic [11:0] shadow_at [0:4095];
    logic [11:0] sched [int];
    logic [11:0] sh;
    exp_t        q [$];
    int          vectors = 0;
    int          miscompares = 0;

    // Displayed number in cycle k: cycles 1..FR-1 show the value held at reset
    // release; each later frame shows the value held at the end of the prior frame.
    function automatic exp_t model(input int k);
        exp_t       e;
        logic [11:0] act;
        logic [3:0]  d;
        int          c, i;
        bit          blank;
        if (k < FR) act = (k == 0) ? 12'h000 : shadow_at[0];
        else        act = shadow_at[FR * (k / FR) - 1];
        c = k % SD;
        i = (k / SD) % 3;
        d = act[4*i +: 4];
        blank = (i == 2 && act[11:8] == 0) || (i == 1 && act[11:4] == 0);
        e.k    = 16'(k);
        e.tick = (k == 0) || (k % FR == FR - 1);
        if (c < DC || blank) begin
            e.seg = 8'h00;
            e.sel = 3'b000;
        end else begin
            e.seg = enc_tab[d];
            e.sel = 3'(1 << i);
        end
        return e;
    endfunction

    function automatic logic [3:0] rnd_digit();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)  return 4'd0;
        if (r == 9) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(1, 9));
    endfunction

    task automatic check_zero(input string name);
        vectors++;
        if (seg_out !== 8'h00 || digit_sel !== 3'b000 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got seg=%h sel=%b tick=%b, need seg=00 sel=000 tick=0",
                     name, seg_out, digit_sel, frame_tick);
        end
    endtask

    // Runs n cycles from reset release; scheduled updates win, else random ones.
    task automatic run(input int n, input int rand_from);
        logic [11:0] v;
        bit          u;
        exp_t        e;
        sh = 12'h000;
        for (int k = 0; k < n; k++) begin
            u = 1'b0;
            v = 12'h000;
            if (sched.exists(k)) begin
                u = 1'b1;
                v = sched[k];
            end else if (k >= rand_from && $urandom_range(0, 5) == 0) begin
                u = 1'b1;
                v = {rnd_digit(), rnd_digit(), rnd_digit()};
            end
            shadow_at[k] = sh;
            update   = u;
            hundreds = u ? v[11:8] : 4'($urandom);
            tens     = u ? v[7:4]  : 4'($urandom);
            ones     = u ? v[3:0]  : 4'($urandom);
            if (u) $display("update k=%0d value=%h", k, v);
            e = model(k);
            @(posedge clk);
            q.push_back(e);
            #1;
            if (u) sh = v;
        end
        update = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (seg_out !== e.seg || digit_sel !== e.sel || frame_tick !== e.tick) begin
                miscompares++;
                $display("FAIL scan k=%0d: got seg=%h sel=%b tick=%b, need seg=%h sel=%b tick=%b",
                         e.k, seg_out, digit_sel, frame_tick, e.seg, e.sel, e.tick);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b0;

        sched[2] = 12'h123;
        run(42, 100000);

        // Mid-slot reset while 123 is on display: outputs must clear at once.
        rst = 1'b1;
        #1;
        check_zero("reset_async");
        q.delete();
        @(posedge clk);
        #1;
        check_zero("reset_pulse");
        rst = 1'b0;

        sched.delete();
        sched[2]   = 12'h007;
        sched[30]  = 12'h000;
        sched[54]  = 12'h105;
        sched[78]  = 12'h123;
        sched[107] = 12'h999;
        sched[140] = 12'h00C;
        run(1200, 170);

        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
